// File: rtl/pulse_player.sv
// rtl/pulse_player.sv - plays one pulse descriptor as a stream of (phase, magnitude) samples
// Read, data and product stages run in lockstep; the FSM only governs issuing reads and draining.
module pulse_player #(
  parameter int PHASE_W    = 16,
  parameter int AMP_W      = 16,
  parameter int TLEN_W     = 16,
  parameter int ENV_ADDR_W = 10,
  parameter int ENV_DATA_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pulse_valid,
  output logic                  pulse_ready,
  input  logic [PHASE_W-1:0]    pulse_phase,
  input  logic [AMP_W-1:0]      pulse_amp,
  input  logic [PHASE_W-1:0]    pulse_freq,
  input  logic [TLEN_W-1:0]     pulse_tlen,
  input  logic [ENV_ADDR_W-1:0] pulse_env_addr,
  output logic                  env_rd_en,
  output logic [ENV_ADDR_W-1:0] env_rd_addr,
  input  logic [ENV_DATA_W-1:0] env_rd_data,
  input  logic                  abort,
  output logic                  out_valid,
  output logic [PHASE_W-1:0]    out_phase,
  output logic [ENV_DATA_W-1:0] out_mag,
  output logic                  pulse_done,
  output logic                  busy
);

  localparam int PROD_W = ENV_DATA_W + AMP_W;

  typedef enum logic [1:0] {IDLE, PLAY, DRAIN} state_t;

  state_t                state, state_nxt;
  logic [AMP_W-1:0]      amp_q;
  logic [PHASE_W-1:0]    freq_q;
  logic [PHASE_W-1:0]    acc_q;
  logic [TLEN_W-1:0]     tlen_q;
  logic [TLEN_W-1:0]     cnt_q;
  logic [ENV_ADDR_W-1:0] addr_q;
  logic                  zero_q;
  logic                  v1;
  logic                  last1;
  logic [PHASE_W-1:0]    ph1;
  logic                  out_last;
  logic                  accept;
  logic                  last_rd;
  logic                  keep;

  assign pulse_ready = (state == IDLE) && !rst;
  assign accept      = pulse_valid && pulse_ready;
  assign busy        = (state != IDLE);
  assign env_rd_en   = (state == PLAY);
  assign env_rd_addr = addr_q;
  assign last_rd     = (state == PLAY) && (cnt_q == tlen_q - TLEN_W'(1));
  // An abort empties the pipeline on the following edge.
  assign keep        = !(abort && busy);
  // Zero-length pulses complete straight from DRAIN with nothing in flight.
  assign pulse_done  = (state == DRAIN) && (zero_q || (out_valid && out_last));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (accept) state_nxt = (pulse_tlen == '0) ? DRAIN : PLAY;
      PLAY:  if (abort) state_nxt = IDLE;
             else if (last_rd) state_nxt = DRAIN;
      DRAIN: if (abort || pulse_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      v1        <= 1'b0;
      last1     <= 1'b0;
      ph1       <= '0;
      out_valid <= 1'b0;
      out_phase <= '0;
      out_mag   <= '0;
      out_last  <= 1'b0;
      amp_q     <= '0;
      freq_q    <= '0;
      acc_q     <= '0;
      tlen_q    <= '0;
      cnt_q     <= '0;
      addr_q    <= '0;
      zero_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        amp_q  <= pulse_amp;
        freq_q <= pulse_freq;
        acc_q  <= pulse_phase;
        tlen_q <= pulse_tlen;
        cnt_q  <= '0;
        addr_q <= pulse_env_addr;
        zero_q <= (pulse_tlen == '0);
      end else if (state == PLAY && !abort) begin
        acc_q  <= acc_q + freq_q;
        cnt_q  <= cnt_q + TLEN_W'(1);
        addr_q <= addr_q + ENV_ADDR_W'(1);
      end
      v1        <= env_rd_en && keep;
      last1     <= last_rd;
      ph1       <= acc_q;
      out_valid <= v1 && keep;
      out_last  <= last1;
      out_phase <= (v1 && keep) ? ph1 : '0;
      out_mag   <= (v1 && keep)
                   ? ENV_DATA_W'((PROD_W'(env_rd_data) * PROD_W'(amp_q)) >> AMP_W)
                   : '0;
    end
  end

endmodule

// File: tb/tb_pulse_player.sv
// tb/tb_pulse_player.sv - randomized and directed bench for pulse_player against a cycle-indexed model
// The model schedules every expected output by absolute cycle number from the accept cycle.
module tb_pulse_player;
  localparam int NC = 8192;

  logic        clk = 0;
  logic        rst, pulse_valid, pulse_ready, abort;
  logic [15:0] pulse_phase, pulse_amp, pulse_freq, pulse_tlen;
  logic [9:0]  pulse_env_addr, env_rd_addr;
  logic        env_rd_en, out_valid, pulse_done, busy;
  logic [15:0] env_rd_data, out_phase, out_mag;

  pulse_player dut (
    .clk(clk), .rst(rst), .pulse_valid(pulse_valid), .pulse_ready(pulse_ready),
    .pulse_phase(pulse_phase), .pulse_amp(pulse_amp), .pulse_freq(pulse_freq),
    .pulse_tlen(pulse_tlen), .pulse_env_addr(pulse_env_addr),
    .env_rd_en(env_rd_en), .env_rd_addr(env_rd_addr), .env_rd_data(env_rd_data),
    .abort(abort), .out_valid(out_valid), .out_phase(out_phase), .out_mag(out_mag),
    .pulse_done(pulse_done), .busy(busy)
  );

  always #5 clk = ~clk;

  logic [15:0] env_mem [1024];
  always @(posedge clk) if (env_rd_en) env_rd_data <= env_mem[env_rd_addr];

  // expected outputs indexed by cycle
  logic        e_busy [NC];
  logic        e_rd   [NC];
  logic [9:0]  e_addr [NC];
  logic        e_val  [NC];
  logic [15:0] e_ph   [NC];
  logic [15:0] e_mag  [NC];
  logic        e_done [NC];

  int n_cmp = 0, n_err = 0;
  int t = 0;
  logic acc_flag;
  logic [15:0] qmag[$], qph[$];
  logic [9:0]  qaddr[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, t);
    end
  endtask

  task automatic clear_after(input int c);
    for (int i = c + 1; i < NC; i++) begin
      e_busy[i] = 0; e_rd[i] = 0; e_addr[i] = 0; e_val[i] = 0;
      e_ph[i] = 0; e_mag[i] = 0; e_done[i] = 0;
    end
  endtask

  task automatic schedule(input int a, input logic [15:0] ph, amp, fr, tl, input logic [9:0] ea);
    logic [31:0] prod;
    logic [9:0]  ad;
    if (tl == 0) begin
      e_busy[a+1] = 1;
      e_done[a+1] = 1;
    end else begin
      for (int n = 0; n < int'(tl); n++) begin
        ad = ea + 10'(n);
        prod = 32'(env_mem[ad]) * 32'(amp);
        e_rd[a+1+n]   = 1;
        e_addr[a+1+n] = ad;
        e_val[a+3+n]  = 1;
        e_ph[a+3+n]   = 16'(32'(ph) + 32'(n) * 32'(fr));
        e_mag[a+3+n]  = prod[31:16];
      end
      for (int c = a + 1; c <= a + int'(tl) + 2; c++) e_busy[c] = 1;
      e_done[a+int'(tl)+2] = 1;
    end
  endtask

  // One clock cycle: drive, compare at the falling edge, advance the model, then clock.
  task automatic step(input logic r, input logic v, input logic [15:0] ph, amp, fr, tl,
                      input logic [9:0] ea, input logic ab);
    logic rdy;
    rst = r; pulse_valid = v; pulse_phase = ph; pulse_amp = amp; pulse_freq = fr;
    pulse_tlen = tl; pulse_env_addr = ea; abort = ab;
    rdy = !e_busy[t] && !r;
    @(negedge clk);
    check("ready", pulse_ready, rdy);
    check("busy", busy, e_busy[t]);
    check("rd_en", env_rd_en, e_rd[t]);
    if (e_rd[t]) check("rd_addr", env_rd_addr, e_addr[t]);
    check("out_valid", out_valid, e_val[t]);
    check("out_phase", out_phase, e_ph[t]);
    check("out_mag", out_mag, e_mag[t]);
    check("pulse_done", pulse_done, e_done[t]);
    if (out_valid) begin qmag.push_back(out_mag); qph.push_back(out_phase); end
    if (env_rd_en) qaddr.push_back(env_rd_addr);
    acc_flag = 0;
    if (r) clear_after(t);
    else if (v && rdy) begin acc_flag = 1; schedule(t, ph, amp, fr, tl, ea); end
    else if (ab && e_busy[t]) clear_after(t);
    @(posedge clk); #1;
    t++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic send(input logic [15:0] ph, amp, fr, tl, input logic [9:0] ea);
    int k = 0;
    do begin
      step(0, 1, ph, amp, fr, tl, ea, 0);
      k++;
    end while (!acc_flag && k < 100);
    if (!acc_flag) check("accept_timeout", 0, 1);
  endtask

  logic [15:0] exp_mag_b[4];
  logic [15:0] exp_ph_w[4];
  logic [9:0]  exp_addr_w[4];

  initial begin
    for (int i = 0; i < 1024; i++) env_mem[i] = 16'($urandom);
    env_mem[10'h010] = 16'h2000; env_mem[10'h011] = 16'h4000;
    env_mem[10'h012] = 16'h6000; env_mem[10'h013] = 16'hFFFF;
    clear_after(-1);
    exp_mag_b  = '{16'h1000, 16'h2000, 16'h3000, 16'h7FFF};
    exp_ph_w   = '{16'hFF00, 16'hFF80, 16'h0000, 16'h0080};
    exp_addr_w = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
    rst = 1; pulse_valid = 0; abort = 0; pulse_phase = 0; pulse_amp = 0;
    pulse_freq = 0; pulse_tlen = 0; pulse_env_addr = 0;
    @(posedge clk); #1;
    step(1, 0, 0, 0, 0, 0, 0, 0);
    idle(2);

    qmag.delete(); qph.delete();
    send(16'h1000, 16'h8000, 16'h0100, 16'd4, 10'h010);
    idle(8);
    check("basic_count", qmag.size(), 4);
    for (int i = 0; i < 4; i++) if (i < qmag.size()) begin
      check("basic_mag", qmag[i], exp_mag_b[i]);
      check("basic_phase", qph[i], 16'h1000 + 16'(i * 16'h0100));
    end

    qph.delete(); qaddr.delete();
    send(16'hFF00, 16'h1234, 16'h0080, 16'd4, 10'h3FE);
    idle(8);
    check("wrap_count", qaddr.size(), 4);
    for (int i = 0; i < 4; i++) if (i < qaddr.size() && i < qph.size()) begin
      check("wrap_addr", qaddr[i], exp_addr_w[i]);
      check("wrap_phase", qph[i], exp_ph_w[i]);
    end

    send(16'h0, 16'h1, 16'h1, 16'd0, 10'h0);
    idle(3);

    send(16'h0100, 16'hFFFF, 16'h0011, 16'd5, 10'h100);
    send(16'h0200, 16'h7FFF, 16'h0022, 16'd3, 10'h200);
    idle(10);

    send(16'h0300, 16'hC000, 16'h0040, 16'd8, 10'h020);
    idle(3);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    idle(12);

    send(16'h0400, 16'hA000, 16'h0040, 16'd8, 10'h030);
    idle(2);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    idle(2);
    qmag.delete();
    send(16'h1000, 16'h8000, 16'h0100, 16'd4, 10'h010);
    idle(8);
    check("fresh_count", qmag.size(), 4);
    if (qmag.size() > 0) check("fresh_first", qmag[0], 16'h1000);

    for (int i = 0; i < 2500 && t < NC - 40; i++)
      step(($urandom % 300) == 0, ($urandom % 3) != 0, 16'($urandom), 16'($urandom),
           16'($urandom), 16'($urandom_range(0, 12)), 10'($urandom), ($urandom % 30) == 0);
    idle(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
